// File: rtl/btn_move_pkg.sv
// Shared direction codes, button indices and the move command record
// for the pushbutton front-end of the 2048 game.
package btn_move_pkg;

    localparam int DIR_W   = 3;
    localparam int NUM_BTN = 5;

    localparam logic [DIR_W-1:0] DIR_UP      = 3'd0;
    localparam logic [DIR_W-1:0] DIR_DOWN    = 3'd1;
    localparam logic [DIR_W-1:0] DIR_LEFT    = 3'd2;
    localparam logic [DIR_W-1:0] DIR_RIGHT   = 3'd3;
    localparam logic [DIR_W-1:0] DIR_NONE    = 3'd4;
    localparam logic [DIR_W-1:0] DIR_NEWGAME = 3'd5;

    // Bit positions in the packed button vector; the four arrows line up
    // with their direction code.
    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_S = 4;

    typedef struct packed {
        logic             valid;
        logic [DIR_W-1:0] dir;
    } move_cmd_t;

    // Highest-priority set button: NEWGAME > UP > DOWN > LEFT > RIGHT.
    function automatic logic [DIR_W-1:0] pick_dir(input logic [NUM_BTN-1:0] v);
        if (v[BTN_S])      return DIR_NEWGAME;
        else if (v[BTN_U]) return DIR_UP;
        else if (v[BTN_D]) return DIR_DOWN;
        else if (v[BTN_L]) return DIR_LEFT;
        else if (v[BTN_R]) return DIR_RIGHT;
        else               return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter, debounced level
// and a single-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb,
    output logic rise
);

    logic [1:0]       sync_ff;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             deb_prev;

    assign sync = sync_ff[1];
    assign rise = deb & ~deb_prev;

    // Bring the asynchronous raw button into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_ff <= '0;
        else      sync_ff <= {sync_ff[0], raw};
    end

    // Level only flips after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sync == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
            deb <= sync;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Previous debounced level for press detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) deb_prev <= 1'b0;
        else      deb_prev <= deb;
    end

endmodule

// File: rtl/btn_move_ctrl.sv
// Pushbutton front-end: debounces the five buttons, arbitrates press
// events into one move command, buffers it for a valid/ready handshake
// and reports live direction plus a saturating dropped-press count.
module btn_move_ctrl
    import btn_move_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5,
    parameter int DROP_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btns,
    input  logic              btnu,
    input  logic              btnd,
    input  logic              btnl,
    input  logic              btnr,
    output logic              move_valid,
    output logic [DIR_W-1:0]  move_dir,
    input  logic              move_ready,
    output logic [DIR_W-1:0]  cur_dir,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] rise;

    assign raw = {btns, btnr, btnl, btnd, btnu};

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_db [NUM_BTN-1:0] (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw),
        .deb  (deb),
        .rise (rise)
    );

    move_cmd_t        cmd, cmd_nxt;
    logic [DIR_W-1:0] win;
    logic [2:0]       n_ev;
    logic [2:0]       drop_inc;
    logic [DROP_W:0]  drop_sum;

    assign win        = pick_dir(rise);
    assign move_valid = cmd.valid;
    assign move_dir   = cmd.dir;
    assign drop_sum   = {1'b0, drop_cnt} + (DROP_W+1)'(drop_inc);

    // Count press events arriving in this cycle.
    always_comb begin
        n_ev = '0;
        for (int i = 0; i < NUM_BTN; i++) n_ev = n_ev + {2'b00, rise[i]};
    end

    // Buffer next state; losers of arbitration and a blocked winner are
    // drops, while NEWGAME replaces whatever is pending.
    always_comb begin
        cmd_nxt  = cmd;
        drop_inc = '0;
        if (n_ev != 3'd0) begin
            drop_inc = n_ev - 3'd1;
            if (!cmd.valid || move_ready || win == DIR_NEWGAME) begin
                cmd_nxt = '{valid: 1'b1, dir: win};
            end else begin
                drop_inc = n_ev;
            end
        end else if (cmd.valid && move_ready) begin
            cmd_nxt = '{valid: 1'b0, dir: DIR_NONE};
        end
    end

    // Command buffer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cmd <= '{valid: 1'b0, dir: DIR_NONE};
        else      cmd <= cmd_nxt;
    end

    // Saturating dropped-press counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 drop_cnt <= '0;
        else if (drop_sum[DROP_W]) drop_cnt <= '1;
        else                      drop_cnt <= drop_sum[DROP_W-1:0];
    end

    // Live direction of the highest-priority held button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur_dir <= DIR_NONE;
        else      cur_dir <= pick_dir(deb);
    end

endmodule

// File: tb/tb_btn_move_ctrl.sv
// Scoreboard bench for btn_move_ctrl: expected move codes are queued
// when a button is driven and compared when the core-side handshake fires.
module tb_btn_move_ctrl;
    import btn_move_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btns = 1'b0, btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [2:0] move_dir;
    logic [2:0] cur_dir;
    logic [7:0] drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];
    int lat;
    int seen;

    always #5 clk = ~clk;

    btn_move_ctrl #(.DB_CYCLES(16), .CNT_W(5), .DROP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .btns       (btns),
        .btnu       (btnu),
        .btnd       (btnd),
        .btnl       (btnl),
        .btnr       (btnr),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .cur_dir    (cur_dir),
        .drop_cnt   (drop_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Ticks 30 cycles, recording the first cycle move_valid is seen high.
    task automatic wait_valid(output int l);
        l = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (move_valid && l == 0) l = i;
        end
    endtask

    task automatic accept();
        chk("acc_valid", move_valid, 1);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
    endtask

    // Handshake monitor: each accepted command must match the queue head.
    always @(negedge clk) begin
        if (rst && move_valid && move_ready) begin
            if (exp_q.size() == 0) chk("sb_empty", exp_q.size(), 1);
            else chk("sb_dir", move_dir, exp_q.pop_front());
        end
    end

    initial begin
        // Reset values
        tick(3);
        chk("rst_valid", move_valid, 0);
        chk("rst_dir", move_dir, 4);
        chk("rst_cur", cur_dir, 4);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b1;
        tick(1);

        // Held DOWN: latency, single event, cur_dir tracking
        btnd = 1'b1;
        exp_q.push_back(1);
        wait_valid(lat);
        chk("t1_lat", lat, 19);
        chk("t1_dir", move_dir, 1);
        chk("t1_cur_hold", cur_dir, 1);
        btnd = 1'b0;
        tick(25);
        chk("t1_cur_rel", cur_dir, 4);
        chk("t1_still_valid", move_valid, 1);
        chk("t1_still_dir", move_dir, 1);
        accept();
        chk("t1_acc_valid", move_valid, 0);
        chk("t1_acc_dir", move_dir, 4);
        tick(25);
        chk("t1_single", move_valid, 0);
        chk("t1_drop", drop_cnt, 0);

        // Bouncing UP never reaches the debounced level
        seen = 0;
        btnu = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(1); if (move_valid || cur_dir != 4) seen = 1; end
        for (int r = 0; r < 5; r++) begin
            btnu = 1'b0;
            for (int i = 0; i < 5; i++) begin tick(1); if (move_valid || cur_dir != 4) seen = 1; end
            btnu = 1'b1;
            for (int i = 0; i < 5; i++) begin tick(1); if (move_valid || cur_dir != 4) seen = 1; end
        end
        btnu = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(1); if (move_valid || cur_dir != 4) seen = 1; end
        chk("t2_bounce", seen, 0);
        chk("t2_drop", drop_cnt, 0);

        // LEFT pending, RIGHT dropped
        btnl = 1'b1;
        exp_q.push_back(2);
        tick(25);
        chk("t3_dir", move_dir, 2);
        btnr = 1'b1;
        tick(25);
        chk("t3_keep", move_dir, 2);
        chk("t3_drop", drop_cnt, 1);
        btnl = 1'b0;
        btnr = 1'b0;
        tick(20);
        accept();
        chk("t3_acc_valid", move_valid, 0);
        chk("t3_acc_dir", move_dir, 4);

        // NEWGAME overwrites pending UP without a drop
        btnu = 1'b1;
        exp_q.push_back(0);
        tick(25);
        btnu = 1'b0;
        chk("t4_up", move_dir, 0);
        btns = 1'b1;
        void'(exp_q.pop_back());
        exp_q.push_back(5);
        tick(25);
        chk("t4_ng", move_dir, 5);
        chk("t4_drop", drop_cnt, 1);
        btns = 1'b0;
        tick(20);
        accept();
        chk("t4_acc_valid", move_valid, 0);

        // Same-cycle UP+RIGHT, then back-to-back accept with DOWN
        btnu = 1'b1;
        btnr = 1'b1;
        exp_q.push_back(0);
        tick(25);
        chk("t5_dir", move_dir, 0);
        chk("t5_drop", drop_cnt, 2);
        btnu = 1'b0;
        btnr = 1'b0;
        tick(20);
        btnd = 1'b1;
        exp_q.push_back(1);
        tick(18);
        move_ready = 1'b1;
        tick(1);
        chk("t5_b2b_valid", move_valid, 1);
        chk("t5_b2b_dir", move_dir, 1);
        chk("t5_b2b_drop", drop_cnt, 2);
        tick(1);
        move_ready = 1'b0;
        chk("t5_end_valid", move_valid, 0);
        chk("t5_end_dir", move_dir, 4);
        btnd = 1'b0;
        tick(20);

        // Reset with DOWN pending and LEFT mid-debounce
        btnd = 1'b1;
        exp_q.push_back(1);
        tick(25);
        btnd = 1'b0;
        chk("t6_pend", move_dir, 1);
        btnl = 1'b1;
        tick(8);
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_valid", move_valid, 0);
        chk("t6_rst_dir", move_dir, 4);
        chk("t6_rst_cur", cur_dir, 4);
        chk("t6_rst_drop", drop_cnt, 0);
        tick(2);
        rst = 1'b1;
        exp_q.push_back(2);
        wait_valid(lat);
        chk("t6_lat", lat, 19);
        chk("t6_dir", move_dir, 2);
        btnl = 1'b0;
        tick(20);
        accept();
        chk("t6_acc_valid", move_valid, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/btn_move_ctrl.md
Name: btn_move_ctrl

Overview:
- Front-end stage between the five raw board pushbuttons (btns/btnu/btnd/btnl/btnr) and the 2048 game core.
- Synchronises and debounces each button, and turns a debounced press into exactly one move command.
- Holds that command in a single-entry buffer and presents it to the game core over a valid/ready handshake.
- Also reports the live direction code and a dropped-press count for debug.

Parameters:
- DB_CYCLES, 16: consecutive stable synchronised samples required before a debounced level changes (min 2).
- CNT_W, 5: width of debounce counter; must satisfy 2**CNT_W > DB_CYCLES.
- DROP_W, 8: width of dropped-press counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- btns  in  1  raw centre button (new game), asynchronous.
- btnu  in  1  raw up button, asynchronous.
- btnd  in  1  raw down button, asynchronous.
- btnl  in  1  raw left button, asynchronous.
- btnr  in  1  raw right button, asynchronous.
- move_valid  out  1  buffered command available.
- move_dir  out  3  command code, stable while move_valid=1.
- move_ready  in  1  game core accepts the command this cycle.
- cur_dir  out  3  code of the highest-priority debounced button currently held; DIR_NONE if none held.
- drop_cnt  out  DROP_W  presses discarded because the buffer was full; saturating.

Behaviour:
- Direction codes: UP=0, DOWN=1, LEFT=2, RIGHT=3, NONE=4, NEWGAME=5. Codes 6 and 7 are never driven.
- Reset (rst=0, async):
  - All synchroniser flops, debounced levels and counters clear to 0.
  - move_valid=0, move_dir=NONE, cur_dir=NONE, drop_cnt=0.
  - A pending command is discarded.
- Synchroniser: 2 flops per button. sync = second flop.
- Debounce, per button:
  - counter cnt; debounced level deb.
  - If sync==deb: cnt<=0.
  - Else if cnt==DB_CYCLES-1: deb<=sync, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any glitch shorter than DB_CYCLES sync samples never reaches deb.
- Edge detect: press event = deb rising (registered previous deb). Release produces no event. Holding a button produces one event only.
- Latency: raw rising at edge k gives deb=1 after edge k+1+DB_CYCLES. move_valid=1 after the following edge, i.e. DB_CYCLES+3 cycles from raw change to move_valid when the buffer is empty.
- Same-cycle arbitration: NEWGAME > UP > DOWN > LEFT > RIGHT. One event is taken. Each lower-priority event in the same cycle increments drop_cnt by 1 (total increment = events-1, saturating).
- Buffer, single entry:
  - Empty and event: load move_dir, move_valid<=1.
  - Full and move_ready=1: entry consumed.
    - If an event arrives in the same cycle, it loads directly and move_valid stays 1; no bubble, no drop.
    - Otherwise move_valid<=0 and move_dir<=NONE.
  - Full, move_ready=0, event: event dropped, drop_cnt+1 (saturate at all-ones). Exception: a NEWGAME event overwrites the pending entry instead, and the overwrite is not counted as a drop.
  - move_dir and move_valid must not change while move_valid=1 and move_ready=0, except for a NEWGAME overwrite.
- move_ready while move_valid=0 is ignored.
- cur_dir: registered from the debounced levels using the same priority order; NONE if all are 0.
- Reset mid-debounce or with a pending command: everything returns to reset values. A button still held after reset release produces an event once debounced (deb starts at 0).

Decomposition:
- Package btn_move_pkg: DIR_UP/DOWN/LEFT/RIGHT/NONE/NEWGAME constants, DIR_W=3.
- Sub-module btn_debounce (synchroniser + counter + deb + rising-edge pulse, params DB_CYCLES/CNT_W), instantiated 5 times.
- Top handles arbitration, buffer, cur_dir and drop_cnt.

Test Plan:
- Reset, then btnd held 30 cycles with DB_CYCLES=16 and move_ready=0 -> move_valid rises exactly 19 cycles after btnd; move_dir=1; cur_dir=1 during hold, 4 after release+debounce; single event only.
- btnu pulse of 10 cycles, then 5-cycle pulses repeating (bounce) -> no move_valid, cur_dir stays 4, drop_cnt=0.
- btnl pressed, not accepted; then btnr pressed -> move_dir stays 2; drop_cnt=1; assert move_ready for 1 cycle -> move_valid=0, move_dir=4.
- btnu pending, btns pressed with move_ready=0 -> move_dir changes 0->5, drop_cnt unchanged; accept -> valid drops.
- btnu and btnr raw rise in the same cycle -> move_dir=0, drop_cnt=1; move_ready held 1 with a later btnd -> back-to-back accept, no bubble.
- rst asserted while btnd is pending and btnl is mid-debounce -> outputs immediately return to reset values; after release with btnl still held -> move_dir=2 after DB_CYCLES+3 cycles.
